// File: rtl/fazyrv_opser_pkg.sv
// ============================================================================
// Module : fazyrv_opser_pkg
// Brief  : Shared types and helpers for the serial-ALU operand sequencer.
//          XLEN: datapath width. opser_state_t: sequencer state encoding.
//          chunks(): number of BWIDTH-bit chunks per XLEN word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fazyrv_opser_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } opser_state_t;

  function automatic int chunks(input int bwidth);
    return XLEN / bwidth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fazyrv_opser_cnt.sv
// ============================================================================
// Module : fazyrv_opser_cnt
// Brief  : Chunk position counter for the operand sequencer. Counts 0..N-1
//          while enabled and wraps to 0 after the last chunk.
// Ports  : clk   - clock (rising edge)
//          rst   - synchronous active-high reset
//          clr   - synchronous clear (new operation accepted)
//          en    - advance one chunk
//          first - counter is at chunk 0
//          last  - counter is at chunk N-1
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fazyrv_opser_cnt #(
  parameter int N = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic first,
  output logic last
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(N - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      // Explicit wrap keeps the counter correct even if N is not a power of two.
      cnt <= (cnt == LAST_VAL) ? '0 : cnt + CW'(1);
    end
  end

  assign first = (cnt == '0);
  assign last  = (cnt == LAST_VAL);

endmodule

`default_nettype wire

// File: rtl/fazyrv_opser.sv
// ============================================================================
// Module : fazyrv_opser
// Brief  : Operand sequencer for the serial ALU. Loads two XLEN operands,
//          streams them LSB-first in BWIDTH-bit chunks with lsb/msb strobes,
//          reassembles the returned result chunks and latches the compare bit.
// Ports  : clk_i, rst_i        - clock, synchronous active-high reset
//          start_i, ready_o     - request / accept handshake
//          busy_o, done_o       - RUN state, one-cycle DONE pulse
//          op_a_i, op_b_i       - operands, sampled on accept
//          a_o, b_o             - current operand chunks to the ALU
//          lsb_o, msb_o         - chunk 0 / chunk N-1 strobes
//          res_i, cmp_i         - ALU result chunk and compare output
//          result_o, cmp_o      - assembled result and captured compare
//          stall_i              - RUN-state hold (FAZYRV_OPSER_STALL_EN only)
// Config : FAZYRV_OPSER_STALL_EN - adds stall_i
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fazyrv_opser
  import fazyrv_opser_pkg::*;
#(
  parameter int BWIDTH = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef FAZYRV_OPSER_STALL_EN
  input  logic              stall_i,
`endif
  input  logic              start_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [BWIDTH-1:0] a_o,
  output logic [BWIDTH-1:0] b_o,
  output logic              lsb_o,
  output logic              msb_o,
  input  logic [BWIDTH-1:0] res_i,
  input  logic              cmp_i,
  output logic [XLEN-1:0]   result_o,
  output logic              cmp_o
);

  localparam int N = chunks(BWIDTH);

  opser_state_t    state;
  logic [XLEN-1:0] sh_a;
  logic [XLEN-1:0] sh_b;
  logic [XLEN-1:0] result;
  logic            cmp;
  logic            stall;
  logic            accept;
  logic            step;
  logic            first;
  logic            last;

`ifdef FAZYRV_OPSER_STALL_EN
  assign stall = stall_i;
`else
  assign stall = 1'b0;
`endif

  assign ready_o = (state == IDLE) || (state == DONE);
  assign busy_o  = (state == RUN);
  assign done_o  = (state == DONE);
  assign accept  = start_i && ready_o;
  assign step    = busy_o && !stall;

  fazyrv_opser_cnt #(
    .N (N)
  ) u_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (accept),
    .en    (step),
    .first (first),
    .last  (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      result <= '0;
      cmp    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            sh_a  <= op_a_i;
            sh_b  <= op_b_i;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!stall) begin
            sh_a   <= sh_a >> BWIDTH;
            sh_b   <= sh_b >> BWIDTH;
            // Result enters from the top so chunk 0 ends up in the LSBs after N steps.
            result <= {res_i, result[XLEN-1:BWIDTH]};
            if (last) begin
              cmp   <= cmp_i;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a_o      = sh_a[BWIDTH-1:0];
  assign b_o      = sh_b[BWIDTH-1:0];
  assign lsb_o    = busy_o && first;
  assign msb_o    = busy_o && last;
  assign result_o = result;
  assign cmp_o    = cmp;

endmodule

`default_nettype wire

// File: tb/tb_fazyrv_opser.sv
// ============================================================================
// Module : tb_fazyrv_opser
// Brief  : Directed self-checking bench for fazyrv_opser at BWIDTH 1/2/4/8,
//          with small serial ALU models (adder, subtractor, passthrough).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fazyrv_opser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  // ---------------- BWIDTH=1 instance: subtractor / passthrough ----------------
  logic        start1 = 0, mode1 = 0;
  logic [31:0] opa1 = 0, opb1 = 0, result1;
  logic        ready1, busy1, done1, lsb1, msb1, cmp1_o, res1, cmp1, c1;
  logic [0:0]  a1, b1;
  logic [1:0]  s1;

  fazyrv_opser #(.BWIDTH(1)) u1 (
    .clk_i(clk), .rst_i(rst),
`ifdef FAZYRV_OPSER_STALL_EN
    .stall_i(1'b0),
`endif
    .start_i(start1), .op_a_i(opa1), .op_b_i(opb1), .ready_o(ready1),
    .busy_o(busy1), .done_o(done1), .a_o(a1), .b_o(b1), .lsb_o(lsb1),
    .msb_o(msb1), .res_i(res1), .cmp_i(cmp1), .result_o(result1), .cmp_o(cmp1_o));

  always_comb begin
    s1 = {1'b0, a1} + {1'b0, ~b1} + {1'b0, (lsb1 ? 1'b1 : c1)};
    if (mode1) begin
      res1 = a1;
      cmp1 = 1'b0;
    end else begin
      res1 = s1[0];
      // signed less-than: differing signs -> A's sign, else sign of difference
      cmp1 = (a1 != b1) ? a1[0] : s1[0];
    end
  end
  always_ff @(posedge clk) c1 <= (rst || !busy1) ? 1'b0 : s1[1];

  // ---------------- BWIDTH=2 instance: adder ----------------
  logic        start2 = 0;
  logic [31:0] opa2 = 0, opb2 = 0, result2;
  logic        ready2, busy2, done2, lsb2, msb2, cmp2_o, c2;
  logic [1:0]  a2, b2, res2;
  logic [2:0]  s2;

  fazyrv_opser #(.BWIDTH(2)) u2 (
    .clk_i(clk), .rst_i(rst),
`ifdef FAZYRV_OPSER_STALL_EN
    .stall_i(1'b0),
`endif
    .start_i(start2), .op_a_i(opa2), .op_b_i(opb2), .ready_o(ready2),
    .busy_o(busy2), .done_o(done2), .a_o(a2), .b_o(b2), .lsb_o(lsb2),
    .msb_o(msb2), .res_i(res2), .cmp_i(1'b0), .result_o(result2), .cmp_o(cmp2_o));

  always_comb begin
    s2   = {1'b0, a2} + {1'b0, b2} + {2'b0, (lsb2 ? 1'b0 : c2)};
    res2 = s2[1:0];
  end
  always_ff @(posedge clk) c2 <= (rst || !busy2) ? 1'b0 : s2[2];

  // ---------------- BWIDTH=4 instance: adder, optional stall ----------------
  logic        start4 = 0, stall4 = 0;
  logic [31:0] opa4 = 0, opb4 = 0, result4;
  logic        ready4, busy4, done4, lsb4, msb4, cmp4_o, c4;
  logic [3:0]  a4, b4, res4;
  logic [4:0]  s4;

  fazyrv_opser #(.BWIDTH(4)) u4 (
    .clk_i(clk), .rst_i(rst),
`ifdef FAZYRV_OPSER_STALL_EN
    .stall_i(stall4),
`endif
    .start_i(start4), .op_a_i(opa4), .op_b_i(opb4), .ready_o(ready4),
    .busy_o(busy4), .done_o(done4), .a_o(a4), .b_o(b4), .lsb_o(lsb4),
    .msb_o(msb4), .res_i(res4), .cmp_i(1'b0), .result_o(result4), .cmp_o(cmp4_o));

  always_comb begin
    s4   = {1'b0, a4} + {1'b0, b4} + {4'b0, (lsb4 ? 1'b0 : c4)};
    res4 = s4[3:0];
  end
  always_ff @(posedge clk) begin
    if (rst)                   c4 <= 1'b0;
    else if (busy4 && !stall4) c4 <= s4[4];
  end

  // ---------------- BWIDTH=8 instance: adder ----------------
  logic        start8 = 0;
  logic [31:0] opa8 = 0, opb8 = 0, result8;
  logic        ready8, busy8, done8, lsb8, msb8, cmp8_o, c8;
  logic [7:0]  a8, b8, res8;
  logic [8:0]  s8;

  fazyrv_opser #(.BWIDTH(8)) u8 (
    .clk_i(clk), .rst_i(rst),
`ifdef FAZYRV_OPSER_STALL_EN
    .stall_i(1'b0),
`endif
    .start_i(start8), .op_a_i(opa8), .op_b_i(opb8), .ready_o(ready8),
    .busy_o(busy8), .done_o(done8), .a_o(a8), .b_o(b8), .lsb_o(lsb8),
    .msb_o(msb8), .res_i(res8), .cmp_i(1'b0), .result_o(result8), .cmp_o(cmp8_o));

  always_comb begin
    s8   = {1'b0, a8} + {1'b0, b8} + {8'b0, (lsb8 ? 1'b0 : c8)};
    res8 = s8[7:0];
  end
  always_ff @(posedge clk) c8 <= (rst || !busy8) ? 1'b0 : s8[8];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int n;
  int busy_cnt;

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_ready",  {31'b0, ready4}, 32'd1);
    check("rst_busy",   {31'b0, busy4},  32'd0);
    check("rst_done",   {31'b0, done4},  32'd0);
    check("rst_lsb",    {31'b0, lsb4},   32'd0);
    check("rst_msb",    {31'b0, msb4},   32'd0);
    check("rst_result", result4,         32'd0);
    check("rst_cmp",    {31'b0, cmp4_o}, 32'd0);
    check("rst_a",      {28'b0, a4},     32'd0);

    // BWIDTH=4 adder: 5 + 3
    opa4 = 32'h0000_0005; opb4 = 32'h0000_0003; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("bw4_a_c0", {28'b0, a4}, 32'h5);
    check("bw4_b_c0", {28'b0, b4}, 32'h3);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("bw4_lsb_c%0d", k), {31'b0, lsb4}, (k == 1) ? 32'd1 : 32'd0);
      check($sformatf("bw4_msb_c%0d", k), {31'b0, msb4}, (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("bw4_busy_c%0d", k), {31'b0, busy4}, 32'd1);
      tick();
    end
    check("bw4_done",   {31'b0, done4},  32'd1);
    check("bw4_ready",  {31'b0, ready4}, 32'd1);
    check("bw4_result", result4,         32'h0000_0008);
    tick();
    check("bw4_done_1cyc", {31'b0, done4}, 32'd0);
    check("bw4_hold",      result4,        32'h0000_0008);

    // BWIDTH=1 subtractor: -1 - 1, signed less-than
    mode1 = 1'b0; opa1 = 32'hFFFF_FFFF; opb1 = 32'h0000_0001; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 40) begin tick(); n++; end
    check("bw1_sub_done",    {31'b0, done1}, 32'd1);
    check("bw1_sub_latency", n,              32'd33);
    check("bw1_sub_ready",   {31'b0, ready1}, 32'd1);
    check("bw1_sub_result",  result1,        32'hFFFF_FFFE);
    check("bw1_sub_cmp",     {31'b0, cmp1_o}, 32'd1);
    tick();

    // BWIDTH=1 passthrough: bit ordering
    mode1 = 1'b1; opa1 = 32'hA5A5_5A5A; opb1 = 32'h0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 40) begin tick(); n++; end
    check("bw1_pass_done",   {31'b0, done1}, 32'd1);
    check("bw1_pass_result", result1,        32'hA5A5_5A5A);
    check("bw1_pass_cmp",    {31'b0, cmp1_o}, 32'd0);
    tick();

    // BWIDTH=8 back-to-back with start held high
    opa8 = 32'h80FF_00FF; opb8 = 32'h8001_0001; start8 = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (busy8) busy_cnt++;
      check($sformatf("bw8_busy_k%0d", k), {31'b0, busy8}, (k % 5 != 0) ? 32'd1 : 32'd0);
      if (k % 5 == 0) begin
        check($sformatf("bw8_done_k%0d", k), {31'b0, done8}, 32'd1);
        check($sformatf("bw8_result_k%0d", k), result8, 32'h0100_0100);
      end
    end
    start8 = 1'b0;
    check("bw8_busy_total", busy_cnt, 32'd16);
    tick();
    check("bw8_idle_ready", {31'b0, ready8}, 32'd1);
    check("bw8_idle_busy",  {31'b0, busy8},  32'd0);

    // BWIDTH=2 reset on RUN cycle 7
    opa2 = 32'h1234_5678; opb2 = 32'h1111_1111; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (6) tick();
    check("bw2_mid_busy", {31'b0, busy2}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("bw2_rst_ready",  {31'b0, ready2}, 32'd1);
    check("bw2_rst_busy",   {31'b0, busy2},  32'd0);
    check("bw2_rst_done",   {31'b0, done2},  32'd0);
    check("bw2_rst_result", result2,         32'd0);
    tick();
    check("bw2_no_done_a", {31'b0, done2}, 32'd0);
    tick();
    check("bw2_no_done_b", {31'b0, done2}, 32'd0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 30) begin tick(); n++; end
    check("bw2_done",    {31'b0, done2}, 32'd1);
    check("bw2_latency", n,              32'd17);
    check("bw2_result",  result2,        32'h2345_6789);
    tick();

`ifdef FAZYRV_OPSER_STALL_EN
    // BWIDTH=4 with a 3-cycle stall on chunk 2
    opa4 = 32'h1234_5678; opb4 = 32'h0F0F_0F0F; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    stall4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_a_%0d", k),   {28'b0, a4}, 32'h6);
      check($sformatf("stall_b_%0d", k),   {28'b0, b4}, 32'hF);
      check($sformatf("stall_lsb_%0d", k), {31'b0, lsb4}, 32'd0);
      check($sformatf("stall_busy_%0d", k), {31'b0, busy4}, 32'd1);
      tick();
    end
    stall4 = 1'b0;
    check("stall_a_after", {28'b0, a4}, 32'h6);
    n = 6;
    while (!done4 && n < 30) begin tick(); n++; end
    check("stall_done",    {31'b0, done4}, 32'd1);
    check("stall_latency", n,              32'd12);
    check("stall_result",  result4,        32'h2143_6587);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fazyrv_opser.md
# fazyrv_opser

Operand sequencer for the serial ALU. It loads two 32-bit operands in parallel and streams them to the ALU in BWIDTH-bit chunks, LSB first. It drives the ALU's chunk-position strobes (lsb/msb), shifts the returned result chunks back into a 32-bit word, and latches the final compare bit. It sits between the register/immediate operand sources and the ALU, and gives the control FSM a start/done handshake.

## Interface
- `BWIDTH`, default 1: chunk width. Legal values are 1, 2, 4 and 8. N = 32/BWIDTH chunks per operation.
- `clk_i` in, 1: clock. Rising edge.
- `rst_i` in, 1: reset. Synchronous and active-high.
- `start_i` in, 1: request a new operation. Accepted only when `ready_o`=1.
- `op_a_i` in, 32: operand A. Sampled on the accept edge.
- `op_b_i` in, 32: operand B. Sampled on the accept edge.
- `ready_o` out, 1: high in IDLE and DONE.
- `busy_o` out, 1: high in RUN.
- `done_o` out, 1: high for exactly one cycle (the DONE state).
- `a_o` out, BWIDTH: current chunk of A, to the ALU.
- `b_o` out, BWIDTH: current chunk of B, to the ALU.
- `lsb_o` out, 1: high during the RUN cycle that presents chunk 0.
- `msb_o` out, 1: high during the RUN cycle that presents chunk N-1.
- `res_i` in, BWIDTH: ALU result chunk for the chunk currently presented.
- `cmp_i` in, 1: ALU compare output.
- `result_o` out, 32: assembled result. Valid from DONE and held until the next accept.
- `cmp_o` out, 1: `cmp_i` sampled on the msb cycle. Held like `result_o`.
- `stall_i` in, 1: present only with `FAZYRV_OPSER_STALL_EN`.

## Operation
- States are IDLE, RUN and DONE. Encoding is in the package.
- **IDLE**: `start_i`=1 loads both operand shift registers, clears the chunk counter and moves to RUN.
- **RUN**:
  - `a_o`/`b_o` are the low BWIDTH bits of the shift registers.
  - `lsb_o` = (cnt==0). `msb_o` = (cnt==N-1).
  - On each edge: operands shift right by BWIDTH with zero fill; `res_i` is shifted into `result_o` from the top (result >> BWIDTH, new chunk in [31:32-BWIDTH]); cnt increments.
  - On the msb edge: `cmp_o` <= `cmp_i` and the state moves to DONE.
- **DONE**: `done_o`=1 for one cycle.
  - `start_i`=1 here is accepted (back-to-back) and goes straight to RUN.
  - Otherwise the state goes to IDLE.
- `start_i` in RUN is ignored and not queued.
- Counter width is $clog2(N), with a minimum of 1. It wraps to 0 at the msb edge. With BWIDTH=8 the counter is 2 bits.
- Outputs stay stable during RUN. The ALU carry/compare registers are owned by the ALU; this block supplies only the strobes.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - Shift registers, `result_o` and `cmp_o` are all 0.
  - `ready_o`=1. `busy_o`, `done_o`, `lsb_o` and `msb_o` are all 0.
- Latency: accept edge → N RUN cycles → 1 DONE cycle.
  - BWIDTH=1: 34 cycles from accept to ready-with-result.
  - BWIDTH=8: 6 cycles from accept to ready-with-result.
- `result_o`/`cmp_o` update on the msb edge. They are valid in the same cycle as `done_o`.
- When N=1 is impossible, lsb and msb never coincide. BWIDTH≤8 guarantees N≥4.
- Reset mid-RUN: the next cycle is IDLE with all registers cleared. A partial result is never exposed with `done_o`.
- Reset and `start_i` in the same cycle: reset wins.

## Configuration
- `FAZYRV_OPSER_STALL_EN` defined:
  - The `stall_i` port exists.
  - While in RUN with `stall_i`=1, the counter, shift registers, `result_o` and `cmp_o` hold, and `res_i` is not sampled.
  - Strobes keep their current values.
  - `stall_i` is ignored in IDLE and DONE.
- Undefined: the port is absent and the logic behaves as `stall_i`=0.

## Structure
- Package `fazyrv_opser_pkg`:
  - `XLEN`=32.
  - State typedef `opser_state_t` {IDLE, RUN, DONE}.
  - Function `chunks(BWIDTH)` returning N.
- Sub-module `fazyrv_opser_cnt`:
  - Parameterised chunk counter with enable and clear.
  - Outputs first/last flags, which drive `lsb_o`/`msb_o`.
- Everything else is in the top module.

## Test plan
- BWIDTH=4, loopback model of an adder:
  - Stimulus: A=0x0000_0005, B=0x0000_0003.
  - `lsb_o` in RUN cycle 1, `msb_o` in cycle 8, `done_o` in cycle 9, `result_o`=0x0000_0008.
- BWIDTH=1, subtractor model with signed compare:
  - Stimulus: A=0xFFFF_FFFF (-1), B=0x0000_0001.
  - `result_o`=0xFFFF_FFFE, and `cmp_o`=1 (less-than) captured from the msb cycle.
- BWIDTH=8:
  - Stimulus: assert `start_i` every cycle.
  - Accepts occur only at the initial IDLE and in each DONE. `busy_o` is high for exactly 4 of every 5 cycles.
- BWIDTH=2, reset mid-operation:
  - Stimulus: assert `rst_i` on RUN cycle 7.
  - Next cycle: IDLE, `result_o`=0, no `done_o` pulse; a following operation completes correctly.
- BWIDTH=4 with `FAZYRV_OPSER_STALL_EN`:
  - Stimulus: 3-cycle stall on chunk 2.
  - `a_o`/`b_o`/cnt are frozen, `done_o` arrives 3 cycles late, and the result is identical to the unstalled run.
- BWIDTH=1, passthrough model (`res_i`=`a_o`):
  - Stimulus: A=0xA5A5_5A5A.
  - `result_o`=0xA5A5_5A5A, which confirms bit ordering.
